// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: inter-stage bus layouts and load-type codes.
// The bus structs are packed MSB-first so they cast directly to and from the flat bus ports.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } ld_type_e;

    typedef struct packed {
        logic       mtc0;
        logic       mfc0;
        logic       eret;
        logic [7:0] addr;
    } c0_bus_t;

    typedef struct packed {
        logic        tlbwi;
        logic        tlbr;
        logic [31:0] badvaddr;
        c0_bus_t     c0;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        logic        mem_req;
        ld_type_e    ld_type;
        logic [1:0]  addr_lo;
        logic [31:0] rt_value;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] alu_res;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        tlbwi;
        logic        tlbr;
        logic [31:0] badvaddr;
        c0_bus_t     c0;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        fwd_valid;
        logic        load_pending;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] result;
    } ms_to_ds_t;

    localparam int unsigned ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int unsigned MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);
    localparam int unsigned MS_TO_DS_BUS_WD = $bits(ms_to_ds_t);

    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects/extends the addressed byte or halfword and merges
// unaligned lwl/lwr data with the old register value.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] result,
    output logic [3:0]  rf_we
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] shift_r;
    logic [31:0] shift_l;
    logic [3:0]  lwl_we;
    logic [3:0]  lwr_we;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        shift_r  = rdata >> {addr_lo, 3'b000};
        // ~addr_lo == 3 - addr_lo for a 2-bit offset
        shift_l  = rdata << {~addr_lo, 3'b000};
        lwl_we   = 4'b1111 << ~addr_lo;
        lwr_we   = 4'b1111 >> addr_lo;

        result = rdata;
        rf_we  = 4'b1111;
        case (ld_type_e'(ld_type))
            LD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: result = {24'd0, byte_sel};
            LD_LH:  result = {{16{half_sel[15]}}, half_sel};
            LD_LHU: result = {16'd0, half_sel};
            LD_LWL: begin
                result = shift_l | (rt & ~byte_mask(lwl_we));
                rf_we  = lwl_we;
            end
            LD_LWR: begin
                result = shift_r | (rt & ~byte_mask(lwr_we));
                rf_we  = lwr_we;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for the data-SRAM response of the held load/store,
// aligns load data, and discards responses that belong to flushed or cancelled requests.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DROP_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_cancel_pending,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    output logic                       ms_ex_eret,
    input  logic                       flush,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    logic            ms_valid;
    es_to_ms_t       ms_bus;
    logic [DROP_W-1:0] drop_cnt;
    logic            buf_valid;
    logic [31:0]     buf_data;

    logic            drop_idle;
    logic            is_load;
    logic            owned_ok;
    logic            ready_go;
    logic            flush_orphan;
    logic            drop_dec;
    logic [DROP_W:0] drop_sum;
    logic [31:0]     load_data;
    logic [31:0]     align_result;
    logic [3:0]      align_we;
    logic [31:0]     result;
    logic [3:0]      out_we;
    ms_to_ws_t       ws_bus;
    ms_to_ds_t       ds_bus;

    always_comb begin
        drop_idle = (drop_cnt == '0);
        is_load   = (ms_bus.ld_type != LD_NONE);
        owned_ok  = drop_idle & ms_valid & ms_bus.mem_req & ~buf_valid & data_sram_data_ok;
        ready_go  = ~ms_bus.mem_req | ms_bus.ex | buf_valid | (data_sram_data_ok & drop_idle);

        ms_allowin     = ~ms_valid | (ready_go & ws_allowin);
        ms_to_ws_valid = ms_valid & ready_go;
        ms_ex_eret     = ms_valid & (ms_bus.ex | ms_bus.c0.eret);

        // A request still in flight when its owner is flushed will answer later; count it.
        flush_orphan = flush & ms_valid & ms_bus.mem_req & ~buf_valid & ~owned_ok;
        drop_dec     = data_sram_data_ok & ~drop_idle;
        drop_sum     = {1'b0, drop_cnt}
                     + {{DROP_W{1'b0}}, es_cancel_pending}
                     + {{DROP_W{1'b0}}, flush_orphan}
                     - {{DROP_W{1'b0}}, drop_dec};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            drop_cnt  <= '0;
            buf_valid <= 1'b0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            drop_cnt <= drop_sum[DROP_W-1:0];
            if (flush || (ms_to_ws_valid && ws_allowin)) begin
                buf_valid <= 1'b0;
            end else if (owned_ok && !ws_allowin) begin
                buf_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            ms_bus <= es_to_ms_t'(es_to_ms_bus);
        end
        if (owned_ok && !ws_allowin) begin
            buf_data <= data_sram_rdata;
        end
    end

    drop_counter_no_overflow: assert property (
        @(posedge clk) disable iff (reset) !drop_sum[DROP_W]
    );

    assign load_data = buf_valid ? buf_data : data_sram_rdata;

    mem_load_align u_load_align (
        .ld_type (ms_bus.ld_type),
        .addr_lo (ms_bus.addr_lo),
        .rdata   (load_data),
        .rt      (ms_bus.rt_value),
        .result  (align_result),
        .rf_we   (align_we)
    );

    always_comb begin
        result = is_load ? align_result : ms_bus.alu_res;
        out_we = (is_load ? (align_we & ms_bus.rf_we) : ms_bus.rf_we)
               & {4{ms_valid & ~ms_bus.ex}};

        ws_bus          = '0;
        ws_bus.tlbwi    = ms_bus.tlbwi;
        ws_bus.tlbr     = ms_bus.tlbr;
        ws_bus.badvaddr = ms_bus.badvaddr;
        ws_bus.c0       = ms_bus.c0;
        ws_bus.bd       = ms_bus.bd;
        ws_bus.ex       = ms_bus.ex;
        ws_bus.excode   = ms_bus.excode;
        ws_bus.rf_we    = out_we;
        ws_bus.dest     = ms_bus.dest;
        ws_bus.result   = result;
        ws_bus.pc       = ms_bus.pc;

        ds_bus              = '0;
        ds_bus.fwd_valid    = ms_valid & (|out_we);
        ds_bus.load_pending = ms_valid & is_load & ~ready_go;
        ds_bus.rf_we        = out_we;
        ds_bus.dest         = ms_bus.dest;
        ds_bus.result       = result;
    end

    assign ms_to_ws_bus = ws_bus;
    assign ms_to_ds_bus = ds_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed alignment vectors, randomized traffic
// against a byte-level reference model, stall buffering, flush/cancel response discarding.
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic        tlbwi;
        logic        tlbr;
        logic [31:0] badvaddr;
        logic [10:0] c0;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        logic        mem_req;
        ld_type_e    ld;
        logic [1:0]  lo;
        logic [31:0] rt;
        logic [3:0]  we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
    } instr_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [162:0] es_to_ms_bus;
    logic         es_cancel_pending;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [124:0] ms_to_ws_bus;
    logic [42:0]  ms_to_ds_bus;
    logic         ms_ex_eret;
    logic         flush;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mem_stage #(.DROP_W(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_cancel_pending (es_cancel_pending),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .ms_ex_eret        (ms_ex_eret),
        .flush             (flush),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: little-endian byte lanes, result built one byte at a time.
    function automatic logic [35:0] ref_out(input instr_t i, input logic [31:0] rd);
        logic [31:0] res;
        logic [3:0]  we;
        logic [7:0]  b;
        logic [15:0] h;
        int          n;
        n   = int'(i.lo);
        res = i.alu;
        we  = i.we;
        b   = rd[8*n +: 8];
        h   = rd[16*(n/2) +: 16];
        case (i.ld)
            LD_LB:  res = {{24{b[7]}}, b};
            LD_LBU: res = {24'd0, b};
            LD_LH:  res = {{16{h[15]}}, h};
            LD_LHU: res = {16'd0, h};
            LD_LW:  res = rd;
            LD_LWL: for (int k = 0; k < 4; k++) begin
                if (k >= 3 - n) begin res[8*k +: 8] = rd[8*(k-3+n) +: 8]; we[k] = 1'b1; end
                else begin res[8*k +: 8] = i.rt[8*k +: 8]; we[k] = 1'b0; end
            end
            LD_LWR: for (int k = 0; k < 4; k++) begin
                if (k + n <= 3) begin res[8*k +: 8] = rd[8*(k+n) +: 8]; we[k] = 1'b1; end
                else begin res[8*k +: 8] = i.rt[8*k +: 8]; we[k] = 1'b0; end
            end
            default: ;
        endcase
        if (i.ex) we = 4'd0;
        return {res, we};
    endfunction

    function automatic logic [162:0] to_es_bus(input instr_t i);
        return {i.tlbwi, i.tlbr, i.badvaddr, i.c0, i.bd, i.ex, i.excode, i.mem_req,
                i.ld, i.lo, i.rt, i.we, i.dest, i.alu, i.pc};
    endfunction

    function automatic logic [124:0] exp_ws(input instr_t i, input logic [31:0] rd);
        logic [35:0] r;
        r = ref_out(i, rd);
        return {i.tlbwi, i.tlbr, i.badvaddr, i.c0, i.bd, i.ex, i.excode,
                r[3:0], i.dest, r[35:4], i.pc};
    endfunction

    function automatic logic [42:0] exp_ds(input instr_t i, input logic [31:0] rd, input logic lp);
        logic [35:0] r;
        r = ref_out(i, rd);
        return {|r[3:0], lp, r[3:0], i.dest, r[35:4]};
    endfunction

    // kind: 0 = ALU, 1 = store, 2 = load
    function automatic instr_t rand_instr(input int kind);
        instr_t i;
        i.tlbwi    = 1'($urandom);
        i.tlbr     = 1'($urandom);
        i.badvaddr = $urandom;
        i.c0       = 11'($urandom) & ~11'h100;
        i.bd       = 1'($urandom);
        i.ex       = 1'b0;
        i.excode   = 5'($urandom);
        i.lo       = 2'($urandom);
        i.rt       = $urandom;
        i.dest     = 5'($urandom);
        i.alu      = $urandom;
        i.pc       = $urandom;
        i.mem_req  = (kind != 0);
        i.ld       = LD_NONE;
        i.we       = (kind == 0) ? 4'($urandom) : 4'd0;
        if (kind == 2) begin
            i.ld = ld_type_e'(3'($urandom_range(1, 7)));
            i.we = 4'hF;
        end
        return i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input instr_t i);
        int unsigned t;
        t = 0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = to_es_bus(i);
        #1;
        while (!ms_allowin && t < 20) begin tick(); #1; t++; end
        n_cmp++;
        if (ms_allowin !== 1'b1) begin
            n_err++;
            $display("FAIL issue_allowin: got %b expected 1 after %0d cycles", ms_allowin, t);
        end
        tick();
        es_to_ms_valid = 1'b0;
    endtask

    task automatic test_reset();
        instr_t i;
        reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; es_cancel_pending = 1'b0;
        ws_allowin = 1'b1; flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", ms_to_ws_valid); end
        n_cmp++; if (ms_ex_eret !== 1'b0) begin n_err++; $display("FAIL reset_ex_eret: got %b expected 0", ms_ex_eret); end
        n_cmp++; if (ms_to_ds_bus[42:41] !== 2'b00) begin n_err++; $display("FAIL reset_fwd_pending: got %b expected 00", ms_to_ds_bus[42:41]); end
        n_cmp++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin); end
        // reset while a load waits empties the stage
        i = rand_instr(2);
        issue(i);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (ms_to_ds_bus[41] !== 1'b0 || ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL reset_midwait: got pending=%b valid=%b expected 0 0", ms_to_ds_bus[41], ms_to_ws_valid); end
    endtask

    task automatic test_load_align();
        ld_type_e    lds [7] = '{LD_LBU, LD_LH, LD_LHU, LD_LWL, LD_LWR, LD_LB, LD_LW};
        logic [1:0]  los [7] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [31:0] rds [7] = '{32'h11223344, 32'h80001234, 32'h80001234, 32'hAABBCCDD, 32'hAABBCCDD, 32'h80FF0000, 32'hDEADBEEF};
        logic [31:0] rts [7] = '{32'h0, 32'h0, 32'h0, 32'h11223344, 32'h11223344, 32'h0, 32'h0};
        logic [31:0] exr [7] = '{32'h00000022, 32'hFFFF8000, 32'h00008000, 32'hCCDD3344, 32'h1122AABB, 32'hFFFFFF80, 32'hDEADBEEF};
        logic [3:0]  exw [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1100, 4'b0011, 4'b1111, 4'b1111};
        instr_t      i;
        logic [124:0] obs;
        for (int k = 0; k < 7; k++) begin
            i = rand_instr(2);
            i.ld = lds[k]; i.lo = los[k]; i.rt = rts[k];
            issue(i);
            data_sram_data_ok = 1'b1; data_sram_rdata = rds[k]; ws_allowin = 1'b1;
            #1;
            obs = ms_to_ws_bus;
            n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL align_valid[%0d]: got %b expected 1", k, ms_to_ws_valid); end
            n_cmp++; if (obs[63:32] !== exr[k]) begin n_err++; $display("FAIL align_result[%0d]: got %h expected %h", k, obs[63:32], exr[k]); end
            n_cmp++; if (obs[72:69] !== exw[k]) begin n_err++; $display("FAIL align_rf_we[%0d]: got %b expected %b", k, obs[72:69], exw[k]); end
            tick();
            data_sram_data_ok = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        instr_t q [6];
        for (int k = 0; k < 6; k++) q[k] = rand_instr(0);
        ws_allowin = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            es_to_ms_valid = (k < 6);
            if (k < 6) es_to_ms_bus = to_es_bus(q[k]);
            #1;
            if (k > 0) begin
                n_cmp++; if (ms_to_ws_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, ms_to_ws_valid); end
                n_cmp++; if (ms_to_ws_bus !== exp_ws(q[k-1], 32'h0)) begin n_err++; $display("FAIL b2b_bus[%0d]: got %h expected %h", k, ms_to_ws_bus, exp_ws(q[k-1], 32'h0)); end
                n_cmp++; if (ms_ex_eret !== 1'b0) begin n_err++; $display("FAIL b2b_ex_eret[%0d]: got %b expected 0", k, ms_ex_eret); end
            end
            n_cmp++; if (ms_allowin !== 1'b1) begin n_err++; $display("FAIL b2b_allowin[%0d]: got %b expected 1", k, ms_allowin); end
            tick();
        end
        es_to_ms_valid = 1'b0;
    endtask

    task automatic test_random();
        instr_t      i;
        logic [31:0] rd;
        int unsigned hold;
        for (int n = 0; n < 60; n++) begin
            i = rand_instr($urandom_range(0, 2));
            ws_allowin = 1'b1;
            issue(i);
            if (i.mem_req) begin
                repeat ($urandom_range(0, 2)) begin
                    data_sram_data_ok = 1'b0;
                    #1;
                    n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL rnd_wait_valid[%0d]: got %b expected 0", n, ms_to_ws_valid); end
                    n_cmp++; if (ms_to_ds_bus[42:32] !== exp_ds(i, 32'h0, i.ld != LD_NONE) >> 32) begin n_err++; $display("FAIL rnd_wait_ds[%0d]: got %h expected %h", n, ms_to_ds_bus[42:32], exp_ds(i, 32'h0, i.ld != LD_NONE) >> 32); end
                    tick();
                end
                rd = $urandom;
                data_sram_data_ok = 1'b1; data_sram_rdata = rd;
                hold = $urandom_range(0, 3);
                ws_allowin = (hold == 0);
                #1;
                n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(i, rd)) begin n_err++; $display("FAIL rnd_resp[%0d]: got v=%b %h expected v=1 %h", n, ms_to_ws_valid, ms_to_ws_bus, exp_ws(i, rd)); end
                n_cmp++; if (ms_to_ds_bus !== exp_ds(i, rd, 1'b0)) begin n_err++; $display("FAIL rnd_resp_ds[%0d]: got %h expected %h", n, ms_to_ds_bus, exp_ds(i, rd, 1'b0)); end
                tick();
                data_sram_data_ok = 1'b0; data_sram_rdata = ~rd;
                if (hold != 0) begin
                    for (int h = 1; h <= int'(hold); h++) begin
                        ws_allowin = (h == int'(hold));
                        #1;
                        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(i, rd)) begin n_err++; $display("FAIL rnd_hold[%0d]: got v=%b %h expected v=1 %h", n, ms_to_ws_valid, ms_to_ws_bus, exp_ws(i, rd)); end
                        n_cmp++; if (ms_to_ds_bus !== exp_ds(i, rd, 1'b0)) begin n_err++; $display("FAIL rnd_hold_ds[%0d]: got %h expected %h", n, ms_to_ds_bus, exp_ds(i, rd, 1'b0)); end
                        tick();
                    end
                end
            end else begin
                #1;
                n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(i, 32'h0)) begin n_err++; $display("FAIL rnd_alu[%0d]: got v=%b %h expected v=1 %h", n, ms_to_ws_valid, ms_to_ws_bus, exp_ws(i, 32'h0)); end
                n_cmp++; if (ms_to_ds_bus !== exp_ds(i, 32'h0, 1'b0)) begin n_err++; $display("FAIL rnd_alu_ds[%0d]: got %h expected %h", n, ms_to_ds_bus, exp_ds(i, 32'h0, 1'b0)); end
                tick();
            end
            ws_allowin = 1'b1;
            #1;
            n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL rnd_drain[%0d]: got %b expected 0", n, ms_to_ws_valid); end
        end
    endtask

    task automatic test_buffer_hold();
        instr_t      i;
        logic [31:0] rd;
        i = rand_instr(2);
        i.ld = LD_LW;
        issue(i);
        rd = $urandom;
        data_sram_data_ok = 1'b1; data_sram_rdata = rd; ws_allowin = 1'b0;
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = ~rd;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== rd) begin n_err++; $display("FAIL buf_hold[%0d]: got v=%b %h expected v=1 %h", c, ms_to_ws_valid, ms_to_ws_bus[63:32], rd); end
            n_cmp++; if (ms_to_ds_bus[41] !== 1'b0) begin n_err++; $display("FAIL buf_pending[%0d]: got %b expected 0", c, ms_to_ds_bus[41]); end
            tick();
        end
        ws_allowin = 1'b1;
        #1;
        n_cmp++; if (ms_to_ws_bus !== exp_ws(i, rd)) begin n_err++; $display("FAIL buf_handoff: got %h expected %h", ms_to_ws_bus, exp_ws(i, rd)); end
        tick();
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL buf_single: got %b expected 0", ms_to_ws_valid); end
    endtask

    task automatic test_flush_drop();
        instr_t      i;
        logic [31:0] rd;
        i = rand_instr(2);
        issue(i);
        flush = 1'b1;
        es_to_ms_valid = 1'b1; es_to_ms_bus = to_es_bus(rand_instr(0));
        tick();
        flush = 1'b0; es_to_ms_valid = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0 || ms_to_ds_bus[42:41] !== 2'b00) begin n_err++; $display("FAIL flush_empty: got v=%b fwd/pend=%b expected 0 00", ms_to_ws_valid, ms_to_ds_bus[42:41]); end
        i = rand_instr(2);
        issue(i);
        data_sram_data_ok = 1'b1; data_sram_rdata = $urandom;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0 || ms_to_ds_bus[41] !== 1'b1) begin n_err++; $display("FAIL flush_stale_drop: got v=%b pend=%b expected 0 1", ms_to_ws_valid, ms_to_ds_bus[41]); end
        tick();
        rd = $urandom; data_sram_rdata = rd;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(i, rd)) begin n_err++; $display("FAIL flush_next_load: got v=%b %h expected v=1 %h", ms_to_ws_valid, ms_to_ws_bus, exp_ws(i, rd)); end
        tick();
        data_sram_data_ok = 1'b0;
        // flush beats a waiting-free allowin
        es_to_ms_valid = 1'b1; es_to_ms_bus = to_es_bus(rand_instr(0)); flush = 1'b1;
        tick();
        es_to_ms_valid = 1'b0; flush = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL flush_over_allowin: got %b expected 0", ms_to_ws_valid); end
        // flush coinciding with the owned response leaves nothing to discard
        i = rand_instr(2);
        issue(i);
        data_sram_data_ok = 1'b1; data_sram_rdata = $urandom; flush = 1'b1;
        tick();
        data_sram_data_ok = 1'b0; flush = 1'b0;
        i = rand_instr(2);
        issue(i);
        rd = $urandom;
        data_sram_data_ok = 1'b1; data_sram_rdata = rd;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(i, rd)) begin n_err++; $display("FAIL flush_with_ok: got v=%b %h expected v=1 %h", ms_to_ws_valid, ms_to_ws_bus, exp_ws(i, rd)); end
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_cancel_and_flush();
        instr_t      i;
        logic [31:0] rd;
        i = rand_instr(2);
        issue(i);
        es_cancel_pending = 1'b1; flush = 1'b1;
        tick();
        es_cancel_pending = 1'b0; flush = 1'b0;
        i = rand_instr(2);
        issue(i);
        for (int d = 0; d < 2; d++) begin
            data_sram_data_ok = 1'b1; data_sram_rdata = $urandom;
            #1;
            n_cmp++; if (ms_to_ws_valid !== 1'b0 || ms_to_ds_bus[41] !== 1'b1) begin n_err++; $display("FAIL cancel_drop[%0d]: got v=%b pend=%b expected 0 1", d, ms_to_ws_valid, ms_to_ds_bus[41]); end
            tick();
        end
        rd = $urandom; data_sram_rdata = rd;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(i, rd)) begin n_err++; $display("FAIL cancel_next_load: got v=%b %h expected v=1 %h", ms_to_ws_valid, ms_to_ws_bus, exp_ws(i, rd)); end
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        n_cmp++; if (ms_to_ws_valid !== 1'b0) begin n_err++; $display("FAIL cancel_drain: got %b expected 0", ms_to_ws_valid); end
    endtask

    task automatic test_exception();
        instr_t      i;
        logic [31:0] rd;
        for (int c = 0; c < 3; c++) begin
            i = rand_instr(c == 2 ? 2 : 0);
            i.we = 4'hF;
            if (c != 1) i.ex = 1'b1;
            if (c == 1) i.c0[8] = 1'b1;
            issue(i);
            rd = $urandom; data_sram_rdata = rd;
            #1;
            n_cmp++; if (ms_ex_eret !== 1'b1) begin n_err++; $display("FAIL exc_ex_eret[%0d]: got %b expected 1", c, ms_ex_eret); end
            n_cmp++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_ws(i, rd)) begin n_err++; $display("FAIL exc_bus[%0d]: got v=%b %h expected v=1 %h", c, ms_to_ws_valid, ms_to_ws_bus, exp_ws(i, rd)); end
            n_cmp++; if (ms_to_ds_bus[42:41] !== {~i.ex, 1'b0}) begin n_err++; $display("FAIL exc_fwd[%0d]: got %b expected %b", c, ms_to_ds_bus[42:41], {~i.ex, 1'b0}); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_align();
        test_back_to_back();
        test_random();
        test_buffer_hold();
        test_flush_drop();
        test_cancel_and_flush();
        test_exception();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
